// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - shared constants and types for the LED flow control stage
package flow_pkg;

  localparam int LEVEL_W = 3;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
  localparam int CNT_W = 32;

  localparam int unsigned BASE_PERIOD_DEF = 50_000_000;
  localparam int unsigned DEBOUNCE_DEF = 1_000_000;

  // Direction encoding understood by the downstream shifter
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    KEY_UP    = 2'd0,
    KEY_DOWN  = 2'd1,
    KEY_DIR   = 2'd2,
    KEY_PAUSE = 2'd3
  } key_idx_e;

  function automatic logic [CNT_W-1:0] period_of(input logic [CNT_W-1:0] base,
                                                 input logic [LEVEL_W-1:0] level);
    return base >> level;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchronizer, level debouncer and rising-edge press pulse
module key_debounce
  import flow_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // Accept the new level; only a 0->1 acceptance counts as a press
        r_stable <= r_sync2;
        r_press  <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_stable = r_stable;
  assign press      = r_press;

endmodule

// File: rtl/flow_step_ctrl.sv
// rtl/flow_step_ctrl.sv - key-driven speed/direction/run state and step strobe generator
module flow_step_ctrl
  import flow_pkg::*;
#(
  parameter int unsigned BASE_PERIOD_CYC = BASE_PERIOD_DEF,
  parameter int unsigned DEBOUNCE_CYC    = DEBOUNCE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_dir,
  input  logic               key_pause,
  output logic               step,
  output logic               dir,
  output logic               running,
  output logic [LEVEL_W-1:0] speed_level
);

  logic [3:0]         w_raw;
  logic [3:0]         w_stable;
  logic [3:0]         w_press;
  logic               w_up;
  logic               w_down;
  logic               w_lvl_inc;
  logic               w_lvl_dec;
  logic               w_lvl_chg;
  logic [CNT_W-1:0]   w_period;
  logic [CNT_W-1:0]   w_period_m1;

  logic               r_step;
  logic               r_dir;
  logic               r_running;
  logic [LEVEL_W-1:0] r_level;
  logic [CNT_W-1:0]   r_cnt;

  assign w_raw = {key_pause, key_dir, key_down, key_up};

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (w_raw[g]),
      .key_stable(w_stable[g]),
      .press     (w_press[g])
    );
  end

  // A press pulse always coincides with the accepted high level
  assign w_up   = w_press[KEY_UP] & w_stable[KEY_UP];
  assign w_down = w_press[KEY_DOWN] & w_stable[KEY_DOWN];

  always_comb begin
    w_lvl_inc = 1'b0;
    w_lvl_dec = 1'b0;
    if (w_up && !w_down && (r_level != LEVEL_MAX)) begin
      w_lvl_inc = 1'b1;
    end
    if (w_down && !w_up && (r_level != '0)) begin
      w_lvl_dec = 1'b1;
    end
    w_lvl_chg = w_lvl_inc | w_lvl_dec;
  end

  assign w_period    = period_of(CNT_W'(BASE_PERIOD_CYC), r_level);
  assign w_period_m1 = w_period - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step    <= 1'b0;
      r_dir     <= DIR_UP;
      r_running <= 1'b1;
      r_level   <= '0;
      r_cnt     <= '0;
    end else begin
      r_step <= 1'b0;
      if (w_lvl_inc) begin
        r_level <= r_level + 1'b1;
      end else if (w_lvl_dec) begin
        r_level <= r_level - 1'b1;
      end
      if (w_press[KEY_DIR]) begin
        r_dir <= ~r_dir;
      end
      if (w_press[KEY_PAUSE]) begin
        r_running <= ~r_running;
      end
      // A level change restarts the period so a stale count never overruns it
      if (w_lvl_chg) begin
        r_cnt <= '0;
      end else if (r_running) begin
        if (r_cnt == w_period_m1) begin
          r_step <= 1'b1;
          r_cnt  <= '0;
        end else if (r_cnt > w_period_m1) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign step        = r_step;
  assign dir         = r_dir;
  assign running     = r_running;
  assign speed_level = r_level;

endmodule

// File: tb/tb_flow_step_ctrl.sv
// tb/tb_flow_step_ctrl.sv - self-checking bench for flow_step_ctrl with a behavioural key/step model
module tb_flow_step_ctrl;

  localparam int BASE = 256;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       k_up = 1'b0;
  logic       k_down = 1'b0;
  logic       k_dir = 1'b0;
  logic       k_pause = 1'b0;
  logic       step;
  logic       dir;
  logic       running;
  logic [2:0] speed_level;

  int   checks = 0;
  int   errors = 0;
  int   acc = 0;
  int   steps_seen = 0;
  int   m_level = 0;
  logic m_dir = 1'b0;
  logic m_run = 1'b1;

  flow_step_ctrl #(
    .BASE_PERIOD_CYC(BASE),
    .DEBOUNCE_CYC   (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_up     (k_up),
    .key_down   (k_down),
    .key_dir    (k_dir),
    .key_pause  (k_pause),
    .step       (step),
    .dir        (dir),
    .running    (running),
    .speed_level(speed_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: ev holds the key presses whose effect lands on the edge just passed.
  // acc counts edges spent running since the last step or level change.
  task automatic tick(input logic [3:0] ev);
    int   nl;
    int   per;
    logic changed;
    @(negedge clk);
    nl = m_level;
    if (ev[0] && !ev[1] && m_level < 7) nl = nl + 1;
    if (ev[1] && !ev[0] && m_level > 0) nl = nl - 1;
    changed = (nl != m_level);
    m_level = nl;
    if (ev[2]) m_dir = ~m_dir;
    if (ev[3]) m_run = ~m_run;
    per = BASE >> m_level;
    if (step === 1'b1) steps_seen++;
    if (changed) begin
      chk("step_on_level_change", 32'(step), 32'd0);
      acc = 0;
    end else if (step === 1'b1) begin
      chk("step_interval", acc, per);
      acc = 0;
    end else begin
      chk("step_overdue", 32'(acc < per), 32'd1);
    end
    chk("speed_level", 32'(speed_level), m_level);
    chk("dir", 32'(dir), 32'(m_dir));
    chk("running", 32'(running), 32'(m_run));
    if (m_run) acc++;
  endtask

  task automatic set_keys(input logic [3:0] m);
    k_up    = m[0];
    k_down  = m[1];
    k_dir   = m[2];
    k_pause = m[3];
  endtask

  // Hold keys for 'hold' cycles; a hold of DEB or more is a press whose
  // state change lands DEB+3 edges after the raw edge.
  task automatic press_keys(input logic [3:0] m, input int hold, input int idle);
    set_keys(m);
    for (int k = 1; k <= hold + DEB + 4 + idle; k++) begin
      tick((hold >= DEB && k == DEB + 3) ? m : 4'b0000);
      if (k == hold) set_keys(4'b0000);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) tick(4'b0000);
  endtask

  task automatic do_reset(input logic [3:0] held);
    rst = 1'b1;
    set_keys(held);
    @(negedge clk);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_running", 32'(running), 32'd1);
    chk("rst_level", 32'(speed_level), 32'd0);
    rst = 1'b0;
    m_level = 0;
    m_dir = 1'b0;
    m_run = 1'b1;
    acc = 1;
  endtask

  initial begin
    int s0;
    do_reset(4'b0000);
    idle_cycles(3 * BASE + 10);
    chk("steps_at_level0", steps_seen, 3);

    press_keys(4'b0001, 3, 2);
    chk("glitch_no_press", 32'(speed_level), 32'd0);
    press_keys(4'b0001, 10, 140);
    chk("level_after_up", 32'(speed_level), 32'd1);

    for (int i = 0; i < 8; i++) press_keys(4'b0001, $urandom_range(DEB, DEB + 5), $urandom_range(0, 8));
    chk("level_saturated_hi", 32'(speed_level), 32'd7);
    idle_cycles(20);
    for (int i = 0; i < 9; i++) press_keys(4'b0010, $urandom_range(DEB, DEB + 5), $urandom_range(0, 8));
    chk("level_saturated_lo", 32'(speed_level), 32'd0);

    press_keys(4'b0001, 6, 20);
    idle_cycles($urandom_range(10, 60));
    press_keys(4'b0011, 6, 150);
    chk("level_both_keys", 32'(speed_level), 32'd1);

    press_keys(4'b1000, 6, 0);
    chk("paused", 32'(running), 32'd0);
    s0 = steps_seen;
    idle_cycles(500);
    chk("steps_while_paused", steps_seen, s0);
    press_keys(4'b1000, 6, 200);
    chk("resumed", 32'(running), 32'd1);

    press_keys(4'b0100, 5, 10);
    chk("dir_toggled", 32'(dir), 32'd1);

    for (int i = 0; i < 40; i++) begin
      press_keys(4'($urandom_range(1, 15)), $urandom_range(1, DEB + 6), $urandom_range(0, 60));
    end

    if (m_run == 1'b0) press_keys(4'b1000, 6, 5);
    press_keys(4'b0001, 6, 5);
    press_keys(4'b0001, 6, 5);
    idle_cycles($urandom_range(3, 40));
    do_reset(4'b0001);
    press_keys(4'b0001, 12, 20);
    chk("held_key_after_reset", 32'(speed_level), 32'd1);
    idle_cycles(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
